// File: rtl/btb_ctrl.sv
// btb_ctrl: lookup index/tag, prediction forming, update write-back and valid-clear
// sweep for the reset-less BTB columns. Optional counters: define BTB_STATS_EN.
module btb_ctrl #(
  parameter int idx_width = 6,
  parameter int tag_width = 32 - idx_width - 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 lookup_valid,
  input  logic [31:0]          lookup_pc,
  output logic                 ready,
  output logic                 pred_hit,
  output logic                 pred_taken,
  output logic [31:0]          pred_target,
  output logic [1:0]           pred_ctr,
  input  logic                 upd_valid,
  input  logic [31:0]          upd_pc,
  input  logic                 upd_taken,
  input  logic [31:0]          upd_target,
  input  logic                 upd_hit,
  input  logic [1:0]           upd_ctr,
  output logic                 col_read,
  output logic [idx_width-1:0] col_r_idx,
  output logic                 col_load,
  output logic [idx_width-1:0] col_w_idx,
  output logic [tag_width-1:0] col_tag_in,
  input  logic [tag_width-1:0] col_tag_out,
  output logic [31:0]          col_tgt_in,
  input  logic [31:0]          col_tgt_out,
  output logic [2:0]           col_meta_in,
  input  logic [2:0]           col_meta_out,
  output logic [31:0]          stat_lookups,
  output logic [31:0]          stat_hits,
  output logic [31:0]          stat_upd_mispred
);

  typedef enum logic {INIT, READY} state_e;

  state_e                 state_q;
  logic [idx_width-1:0]   init_idx_q;
  logic                   ready_q;

  logic                   upd_v_q;
  logic [idx_width-1:0]   upd_idx_q;
  logic [tag_width-1:0]   upd_tag_q;
  logic [31:0]            upd_tgt_q;
  logic                   upd_taken_q;
  logic                   upd_hit_q;
  logic [1:0]             upd_ctr_q;

  logic [tag_width-1:0]   lookup_tag;
  logic [1:0]             ctr_d;
  logic                   upd_write;

  // NOTE: sequential state is assigned with <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT;
      init_idx_q <= '0;
      ready_q    <= 1'b0;
      upd_v_q    <= 1'b0;
    end else if (flush) begin
      state_q    <= INIT;
      init_idx_q <= '0;
      ready_q    <= 1'b0;
      upd_v_q    <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          init_idx_q <= init_idx_q + 1'b1;
          upd_v_q    <= 1'b0;
          if (&init_idx_q) begin
            state_q <= READY;
            ready_q <= 1'b1;
          end
        end
        READY: upd_v_q <= upd_valid;
        default: begin
          state_q    <= INIT;
          init_idx_q <= '0;
          ready_q    <= 1'b0;
          upd_v_q    <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the update payload is not reset; upd_v_q alone qualifies it, like the columns' own contents.
  always_ff @(posedge clk) begin
    if (state_q == READY && upd_valid) begin
      upd_idx_q   <= upd_pc[idx_width+1:2];
      upd_tag_q   <= upd_pc[31:idx_width+2];
      upd_tgt_q   <= upd_target;
      upd_taken_q <= upd_taken;
      upd_hit_q   <= upd_hit;
      upd_ctr_q   <= upd_ctr;
    end
  end

  assign ready = ready_q;

  // Column outputs are undefined unless read; every pred_* term is gated by col_read.
  assign lookup_tag  = lookup_pc[31:idx_width+2];
  assign col_read    = lookup_valid && ready_q;
  assign col_r_idx   = lookup_pc[idx_width+1:2];
  assign pred_hit    = col_read && col_meta_out[2] && (col_tag_out == lookup_tag);
  assign pred_taken  = pred_hit && col_meta_out[1];
  assign pred_target = pred_hit ? col_tgt_out : 32'h0;
  assign pred_ctr    = pred_hit ? col_meta_out[1:0] : 2'b00;

  // A flush in the write cycle drops the pending update.
  assign upd_write = upd_v_q && !flush && (upd_hit_q || upd_taken_q);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    ctr_d = upd_ctr_q;
    if (upd_taken_q) begin
      if (upd_ctr_q != 2'b11) ctr_d = upd_ctr_q + 2'b01;
    end else begin
      if (upd_ctr_q != 2'b00) ctr_d = upd_ctr_q - 2'b01;
    end
  end

  always_comb begin
    col_load    = 1'b0;
    col_w_idx   = init_idx_q;
    col_tag_in  = '0;
    col_tgt_in  = 32'h0;
    col_meta_in = 3'b000;
    if (state_q == INIT) begin
      col_load = 1'b1;
    end else if (upd_write) begin
      col_load    = 1'b1;
      col_w_idx   = upd_idx_q;
      col_tag_in  = upd_tag_q;
      col_tgt_in  = upd_tgt_q;
      col_meta_in = {1'b1, (upd_hit_q ? ctr_d : 2'b10)};
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] lookups_q;
  logic [31:0] hits_q;
  logic [31:0] mispred_q;
  logic        mispred;

  assign mispred = (upd_hit_q && upd_ctr_q[1]) != upd_taken_q;

  // Counters survive flush and saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      lookups_q <= '0;
      hits_q    <= '0;
      mispred_q <= '0;
    end else begin
      if (col_read && lookups_q != '1) lookups_q <= lookups_q + 32'd1;
      if (pred_hit && hits_q != '1) hits_q <= hits_q + 32'd1;
      if (upd_v_q && !flush && mispred && mispred_q != '1) mispred_q <= mispred_q + 32'd1;
    end
  end

  assign stat_lookups     = lookups_q;
  assign stat_hits        = hits_q;
  assign stat_upd_mispred = mispred_q;
`else
  assign stat_lookups     = 32'h0;
  assign stat_hits        = 32'h0;
  assign stat_upd_mispred = 32'h0;
`endif

  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

endmodule

// File: tb/tb_btb_ctrl.sv
// Testbench for btb_ctrl: behavioural column arrays with write bypass, plus a
// table-level reference model of the BTB contents and the update pipeline.
module tb_btb_ctrl;
  localparam int IW = 6;
  localparam int TW = 24;
  localparam int NE = 64;

  logic          clk = 1'b0;
  logic          rst, flush, lookup_valid, upd_valid, upd_taken, upd_hit;
  logic [31:0]   lookup_pc, upd_pc, upd_target;
  logic [1:0]    upd_ctr;
  logic          ready, pred_hit, pred_taken, col_read, col_load;
  logic [31:0]   pred_target, col_tgt_in, col_tgt_out;
  logic [1:0]    pred_ctr;
  logic [IW-1:0] col_r_idx, col_w_idx;
  logic [TW-1:0] col_tag_in, col_tag_out;
  logic [2:0]    col_meta_in, col_meta_out;
  logic [31:0]   stat_lookups, stat_hits, stat_upd_mispred;

  always #5 clk = ~clk;

  btb_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .ready(ready), .pred_hit(pred_hit), .pred_taken(pred_taken),
    .pred_target(pred_target), .pred_ctr(pred_ctr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_hit(upd_hit), .upd_ctr(upd_ctr),
    .col_read(col_read), .col_r_idx(col_r_idx), .col_load(col_load),
    .col_w_idx(col_w_idx), .col_tag_in(col_tag_in), .col_tag_out(col_tag_out),
    .col_tgt_in(col_tgt_in), .col_tgt_out(col_tgt_out),
    .col_meta_in(col_meta_in), .col_meta_out(col_meta_out),
    .stat_lookups(stat_lookups), .stat_hits(stat_hits),
    .stat_upd_mispred(stat_upd_mispred)
  );

  // Column arrays: no reset, read data undefined unless read, same-cycle write bypass.
  logic [TW-1:0] c_tag  [NE];
  logic [31:0]   c_tgt  [NE];
  logic [2:0]    c_meta [NE];

  always_comb begin
    col_tag_out  = 'x;
    col_tgt_out  = 'x;
    col_meta_out = 'x;
    if (col_read) begin
      if (col_load && col_w_idx == col_r_idx) begin
        col_tag_out  = col_tag_in;
        col_tgt_out  = col_tgt_in;
        col_meta_out = col_meta_in;
      end else begin
        col_tag_out  = c_tag[col_r_idx];
        col_tgt_out  = c_tgt[col_r_idx];
        col_meta_out = c_meta[col_r_idx];
      end
    end
  end

  always @(posedge clk) begin
    if (col_load) begin
      c_tag[col_w_idx]  <= col_tag_in;
      c_tgt[col_w_idx]  <= col_tgt_in;
      c_meta[col_w_idx] <= col_meta_in;
    end
  end

  // Reference model: a table of entries plus one pending resolved branch.
  typedef struct packed {
    logic          v;
    logic [1:0]    ctr;
    logic [TW-1:0] tag;
    logic [31:0]   tgt;
  } ent_t;

  typedef struct packed {
    logic          valid;
    logic [IW-1:0] idx;
    logic [TW-1:0] tag;
    logic [31:0]   tgt;
    logic          taken;
    logic          hit;
    logic [1:0]    ctr;
  } pend_t;

  ent_t   m_tab [NE];
  pend_t  m_p;
  logic   m_ready;
  int     m_cnt;
  int     m_lookups, m_hits, m_mispred;
  logic   e_read, e_hit;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic ent_t resolved(input pend_t q);
    ent_t e;
    int   c;
    e.v   = 1'b1;
    e.tag = q.tag;
    e.tgt = q.tgt;
    if (q.hit) begin
      c = int'(q.ctr);
      c = q.taken ? ((c + 1 > 3) ? 3 : c + 1) : ((c - 1 < 0) ? 0 : c - 1);
      e.ctr = 2'(c);
    end else begin
      e.ctr = 2'b10;
    end
    return e;
  endfunction

  function automatic logic writes(input pend_t q, input logic fl);
    return q.valid && !fl && (q.hit || q.taken);
  endfunction

  // Drive one cycle's inputs (at the falling edge) and compare every output with the model.
  task automatic drive(input logic lv, input logic [31:0] lpc, input logic uv,
                       input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                       input logic uh, input logic [1:0] uc, input logic fl);
    ent_t e;
    logic e_load;
    lookup_valid = lv; lookup_pc = lpc;
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
    upd_hit = uh; upd_ctr = uc; flush = fl;
    #1;
    e = m_tab[lpc[7:2]];
    if (m_ready && writes(m_p, fl) && m_p.idx == lpc[7:2]) e = resolved(m_p);
    e_read = lv && m_ready;
    e_hit  = e_read && e.v && (e.tag == lpc[31:8]);
    e_load = !m_ready || writes(m_p, fl);
    check("ready", 32'(ready), 32'(m_ready));
    check("col_read", 32'(col_read), 32'(e_read));
    check("col_r_idx", 32'(col_r_idx), 32'(lpc[7:2]));
    check("pred_hit", 32'(pred_hit), 32'(e_hit));
    check("pred_taken", 32'(pred_taken), 32'(e_hit && e.ctr[1]));
    check("pred_target", pred_target, e_hit ? e.tgt : 32'h0);
    check("pred_ctr", 32'(pred_ctr), e_hit ? 32'(e.ctr) : 32'h0);
    check("col_load", 32'(col_load), 32'(e_load));
    if (e_load) begin
      if (!m_ready) begin
        check("init_w_idx", 32'(col_w_idx), 32'(m_cnt));
        check("init_meta", 32'(col_meta_in), 32'h0);
        check("init_tag", 32'(col_tag_in), 32'h0);
        check("init_tgt", col_tgt_in, 32'h0);
      end else begin
        e = resolved(m_p);
        check("upd_w_idx", 32'(col_w_idx), 32'(m_p.idx));
        check("upd_meta", 32'(col_meta_in), 32'({e.v, e.ctr}));
        check("upd_tag", 32'(col_tag_in), 32'(e.tag));
        check("upd_tgt", col_tgt_in, e.tgt);
      end
    end
`ifdef BTB_STATS_EN
    check("stat_lookups", stat_lookups, 32'(m_lookups));
    check("stat_hits", stat_hits, 32'(m_hits));
    check("stat_mispred", stat_upd_mispred, 32'(m_mispred));
`else
    check("stat_lookups", stat_lookups, 32'h0);
    check("stat_hits", stat_hits, 32'h0);
    check("stat_mispred", stat_upd_mispred, 32'h0);
`endif
  endtask

  // Advance one clock and apply the same edge to the model.
  task automatic tick();
    @(posedge clk);
    if (!m_ready) begin
      m_tab[m_cnt] = '0;
    end else if (writes(m_p, flush)) begin
      m_tab[m_p.idx] = resolved(m_p);
    end
    if (rst) begin
      m_lookups = 0; m_hits = 0; m_mispred = 0;
    end else begin
      m_lookups += int'(e_read);
      m_hits    += int'(e_hit);
      if (m_p.valid && !flush && ((m_p.hit && m_p.ctr[1]) != m_p.taken)) m_mispred++;
    end
    if (rst || flush) begin
      m_ready = 1'b0; m_cnt = 0; m_p = '0;
    end else if (!m_ready) begin
      if (m_cnt == NE - 1) m_ready = 1'b1;
      m_cnt = (m_cnt + 1) % NE;
    end else begin
      m_p.valid = upd_valid;
      m_p.idx   = upd_pc[7:2];
      m_p.tag   = upd_pc[31:8];
      m_p.tgt   = upd_target;
      m_p.taken = upd_taken;
      m_p.hit   = upd_hit;
      m_p.ctr   = upd_ctr;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic look(input logic [31:0] pc);
    drive(1'b1, pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                     input logic h, input logic [1:0] c);
    drive(1'b0, 32'h0, 1'b1, pc, t, tgt, h, c, 1'b0);
  endtask

  task automatic do_flush();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 2'b00, 1'b1);
  endtask

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    while (ready !== 1'b1 && k < 200) begin
      idle(); tick(); k++;
    end
    check(tag, 32'(ready), 32'h1);
  endtask

  function automatic logic [31:0] rpc();
    logic [23:0] t;
    logic [5:0]  i;
    t = 24'($urandom_range(0, 3)) + 24'h10;
    i = 6'($urandom_range(0, 3));
    return {t, i, 2'($urandom_range(0, 3))};
  endfunction

  logic [1:0] seq_ctr_in  [5] = '{2'd2, 2'd3, 2'd3, 2'd3, 2'd2};
  logic       seq_taken   [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [1:0] seq_ctr_out [5] = '{2'd3, 2'd3, 2'd3, 2'd2, 2'd1};

  initial begin
    m_ready = 1'b0; m_cnt = 0; m_p = '0;
    m_lookups = 0; m_hits = 0; m_mispred = 0;
    e_read = 1'b0; e_hit = 1'b0;
    for (int i = 0; i < NE; i++) m_tab[i] = '0;
    rst = 1'b1; flush = 1'b0; lookup_valid = 1'b0; lookup_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    upd_hit = 1'b0; upd_ctr = '0;
    @(posedge clk); @(posedge clk); @(negedge clk);

    // Reset, then a full 64-cycle sweep; lookups and updates are ignored while it runs.
    idle(); tick();
    rst = 1'b0;
    for (int i = 0; i < NE; i++) begin
      drive(1'b1, rpc(), 1'b1, rpc(), 1'b1, 32'h1234, 1'b0, 2'b00, 1'b0);
      tick();
    end
    look(32'h0000_1040);
    check("ready_cycle65", 32'(ready), 32'h1);
    check("miss_after_sweep", 32'(pred_hit), 32'h0);
    tick();

    // Allocation of a taken miss, visible through the bypass and then from the array.
    upd(32'h0000_1040, 1'b1, 32'h2000, 1'b0, 2'b00); tick();
    look(32'h0000_1040);
    check("alloc_byp_hit", 32'(pred_hit), 32'h1);
    check("alloc_byp_tgt", pred_target, 32'h2000);
    tick();
    look(32'h0000_1040);
    check("alloc_hit", 32'(pred_hit), 32'h1);
    check("alloc_taken", 32'(pred_taken), 32'h1);
    check("alloc_tgt", pred_target, 32'h2000);
    check("alloc_ctr", 32'(pred_ctr), 32'h2);
    tick();

    // Counter training on a hit: saturate at 3, then walk down to 1.
    for (int i = 0; i < 5; i++) begin
      upd(32'h0000_1040, seq_taken[i], 32'h2000, 1'b1, seq_ctr_in[i]); tick();
      look(32'h0000_1040);
      check("train_ctr", 32'(pred_ctr), 32'(seq_ctr_out[i]));
      tick();
    end
    look(32'h0000_1040);
    check("train_hit", 32'(pred_hit), 32'h1);
    check("train_taken", 32'(pred_taken), 32'h0);
    tick();

    // Not-taken miss: no column write.
    upd(32'h0000_3000, 1'b0, 32'h9999, 1'b0, 2'b00); tick();
    idle();
    check("nt_miss_noload", 32'(col_load), 32'h0);
    tick();
    look(32'h0000_3000);
    check("nt_miss_lookup", 32'(pred_hit), 32'h0);
    tick();

    // Aliasing: same index, different tag replaces the occupant.
    look(32'h0000_2040);
    check("alias_miss", 32'(pred_hit), 32'h0);
    tick();
    upd(32'h0000_2040, 1'b1, 32'h5000, 1'b0, 2'b00); tick();
    idle(); tick();
    look(32'h0000_2040);
    check("alias_hit", 32'(pred_hit), 32'h1);
    check("alias_tgt", pred_target, 32'h5000);
    tick();
    look(32'h0000_1040);
    check("alias_evicted", 32'(pred_hit), 32'h0);
    tick();

    // Flush in READY, then again at sweep index 20.
    do_flush(); tick();
    for (int i = 0; i < 20; i++) begin idle(); tick(); end
    do_flush();
    check("flush_at_20", 32'(col_w_idx), 32'd20);
    tick();
    idle();
    check("sweep_restart", 32'(col_w_idx), 32'd0);
    tick();
    wait_ready("ready_after_flush");
    look(32'h0000_2040);
    check("flush_miss", 32'(pred_hit), 32'h0);
    tick();

    // Flush with an update registered: the update is dropped.
    upd(32'h0000_4000, 1'b1, 32'h8000, 1'b0, 2'b00); tick();
    do_flush();
    check("flush_drops_upd", 32'(col_load), 32'h0);
    tick();
    wait_ready("ready_after_flush2");
    look(32'h0000_4000);
    check("dropped_miss", 32'(pred_hit), 32'h0);
    tick();

    // Randomized traffic over a few aliasing PCs, with occasional flushes.
    for (int n = 0; n < 2500; n++) begin
      drive(1'($urandom_range(0, 1)), rpc(),
            1'($urandom_range(0, 1)), rpc(), 1'($urandom_range(0, 1)),
            $urandom(), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 199) == 0));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
